// File: rtl/tile_accumulator.sv
// Lane-wise accumulator: sums NUM_TILES 4-double partial vectors from the adder tree
// using four strobe/ack double_adder units, then hands the result to writeback.

module double_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] a,
    input  logic        a_stb,
    output logic        a_ack,
    input  logic [63:0] b,
    input  logic        b_stb,
    output logic        b_ack,
    output logic [63:0] z,
    output logic        z_stb,
    input  logic        z_ack
);

    typedef enum logic [1:0] {GET_A, GET_B, CALC, PUT_Z} add_state_t;

    add_state_t  state_q, state_d;
    logic [63:0] a_q, a_d, b_q, b_d, z_q, z_d;
    logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;

    // Round-to-nearest-even IEEE-754 double addition, including subnormals and specials.
    function automatic logic [63:0] fp_add(input logic [63:0] in_a, input logic [63:0] in_b);
        logic [63:0] x, y, r;
        logic        a_nan, b_nan, a_inf, b_inf, rnd;
        logic [12:0] ex, ey, d, e, sh;
        logic [55:0] mx, my, my_sh, mask, n;
        logic [56:0] sum;
        logic [53:0] mr;
        logic [6:0]  lz;
        a_nan = (in_a[62:52] == 11'h7FF) && (in_a[51:0] != 52'd0);
        b_nan = (in_b[62:52] == 11'h7FF) && (in_b[51:0] != 52'd0);
        a_inf = (in_a[62:52] == 11'h7FF) && (in_a[51:0] == 52'd0);
        b_inf = (in_b[62:52] == 11'h7FF) && (in_b[51:0] == 52'd0);
        r = 64'd0;
        if (a_nan || b_nan || (a_inf && b_inf && (in_a[63] != in_b[63]))) begin
            r = 64'h7FF8000000000000;
        end else if (a_inf) begin
            r = in_a;
        end else if (b_inf) begin
            r = in_b;
        end else begin
            if (in_a[62:0] < in_b[62:0]) begin
                x = in_b;
                y = in_a;
            end else begin
                x = in_a;
                y = in_b;
            end
            ex = (x[62:52] == 11'd0) ? 13'd1 : {2'b00, x[62:52]};
            ey = (y[62:52] == 11'd0) ? 13'd1 : {2'b00, y[62:52]};
            mx = {(x[62:52] != 11'd0), x[51:0], 3'b000};
            my = {(y[62:52] != 11'd0), y[51:0], 3'b000};
            d = ex - ey;
            // Bits shifted out of the smaller operand collapse into the sticky bit.
            mask = ~({56{1'b1}} << d);
            my_sh = my >> d;
            my_sh[0] = my_sh[0] | (|(my & mask));
            if (x[63] == y[63]) begin
                sum = {1'b0, mx} + {1'b0, my_sh};
            end else begin
                sum = {1'b0, mx} - {1'b0, my_sh};
            end
            e = ex;
            if (sum == 57'd0) begin
                r = {x[63] & y[63], 63'd0};
            end else begin
                if (sum[56]) begin
                    n = {sum[56:2], sum[1] | sum[0]};
                    e = e + 13'd1;
                end else begin
                    n = sum[55:0];
                    lz = 7'd56;
                    for (int i = 0; i < 56; i++) begin
                        if (n[i]) begin
                            lz = 7'(55 - i);
                        end
                    end
                    sh = (13'(lz) < (e - 13'd1)) ? 13'(lz) : (e - 13'd1);
                    n = n << sh;
                    e = e - sh;
                end
                rnd = n[2] & (n[1] | n[0] | n[3]);
                mr = {1'b0, n[55:3]} + {53'd0, rnd};
                if (mr[53]) begin
                    mr = mr >> 1;
                    e = e + 13'd1;
                end
                if (e >= 13'd2047) begin
                    r = {x[63], 11'h7FF, 52'd0};
                end else begin
                    r = {x[63], (mr[52] ? e[10:0] : 11'd0), mr[51:0]};
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        z_d     = z_q;
        a_ack_d = 1'b0;
        b_ack_d = 1'b0;
        z_stb_d = z_stb_q;
        case (state_q)
            GET_A: if (a_stb) begin
                a_d     = a;
                a_ack_d = 1'b1;
                state_d = GET_B;
            end
            GET_B: if (b_stb) begin
                b_d     = b;
                b_ack_d = 1'b1;
                state_d = CALC;
            end
            CALC: begin
                z_d     = fp_add(a_q, b_q);
                z_stb_d = 1'b1;
                state_d = PUT_Z;
            end
            PUT_Z: if (z_ack) begin
                z_stb_d = 1'b0;
                state_d = GET_A;
            end
            default: state_d = GET_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= GET_A;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            z_stb_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z_q     <= z_d;
            a_ack_q <= a_ack_d;
            b_ack_q <= b_ack_d;
            z_stb_q <= z_stb_d;
        end
    end

    assign a_ack = a_ack_q;
    assign b_ack = b_ack_q;
    assign z     = z_q;
    assign z_stb = z_stb_q;

endmodule

module tile_accumulator #(
    parameter int NUM_TILES = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [255:0]     c_in,
    input  logic             c_done,
    output logic [255:0]     result,
    output logic             result_valid,
    input  logic             result_ack,
    output logic             busy,
    output logic             overrun,
    output logic [CNT_W-1:0] tile_cnt
);

    localparam logic [CNT_W-1:0] TILES_C = CNT_W'(NUM_TILES);

    typedef enum logic [2:0] {IDLE, LOAD, ADD, WAIT, CHECK, OUT} state_t;

    state_t           state_q, state_d;
    logic [255:0]     cur_q, cur_d, acc_q, acc_d, pend_q, pend_d, result_q, result_d;
    logic             pend_full_q, pend_full_d, overrun_q, overrun_d;
    logic             result_valid_q, result_valid_d;
    logic [CNT_W-1:0] tile_cnt_q, tile_cnt_d;
    logic [3:0]       a_stb_q, a_stb_d, b_stb_q, b_stb_d, z_ack_q, z_ack_d;
    logic [3:0]       lane_done_q, lane_done_d;
    logic [3:0]       a_ack, b_ack, z_stb;
    logic [63:0]      z_lane [4];

    for (genvar g = 0; g < 4; g++) begin : g_lane
        double_adder u_add (
            .clk   (clk),
            .rst   (rst),
            .a     (acc_q[g*64 +: 64]),
            .a_stb (a_stb_q[g]),
            .a_ack (a_ack[g]),
            .b     (cur_q[g*64 +: 64]),
            .b_stb (b_stb_q[g]),
            .b_ack (b_ack[g]),
            .z     (z_lane[g]),
            .z_stb (z_stb[g]),
            .z_ack (z_ack_q[g])
        );
    end

    always_comb begin
        state_d        = state_q;
        cur_d          = cur_q;
        acc_d          = acc_q;
        pend_d         = pend_q;
        pend_full_d    = pend_full_q;
        overrun_d      = overrun_q;
        tile_cnt_d     = tile_cnt_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        a_stb_d        = a_stb_q;
        b_stb_d        = b_stb_q;
        z_ack_d        = '0;
        lane_done_d    = lane_done_q;

        // Only an idle block with nothing queued takes a tile directly; all else queues or drops.
        if (c_done) begin
            if (state_q == IDLE && !pend_full_q) begin
                cur_d = c_in;
            end else if (!pend_full_q) begin
                pend_d      = c_in;
                pend_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (c_done && !pend_full_q) begin
                    state_d = LOAD;
                end else if (pend_full_q) begin
                    cur_d       = pend_q;
                    pend_full_d = 1'b0;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (tile_cnt_q == '0) begin
                    acc_d      = cur_q;
                    tile_cnt_d = CNT_W'(1);
                    state_d    = CHECK;
                end else begin
                    a_stb_d = 4'hF;
                    b_stb_d = 4'hF;
                    state_d = ADD;
                end
            end
            ADD: begin
                for (int i = 0; i < 4; i++) begin
                    if (a_ack[i]) a_stb_d[i] = 1'b0;
                    if (b_ack[i]) b_stb_d[i] = 1'b0;
                end
                if ((a_stb_d | b_stb_d) == 4'h0) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                for (int i = 0; i < 4; i++) begin
                    if (z_stb[i] && !lane_done_q[i]) begin
                        acc_d[i*64 +: 64] = z_lane[i];
                        z_ack_d[i]        = 1'b1;
                        lane_done_d[i]    = 1'b1;
                    end
                end
                if (&lane_done_q) begin
                    lane_done_d = '0;
                    tile_cnt_d  = tile_cnt_q + CNT_W'(1);
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (tile_cnt_q == TILES_C) begin
                    result_d       = acc_q;
                    result_valid_d = 1'b1;
                    state_d        = OUT;
                end else begin
                    state_d = IDLE;
                end
            end
            OUT: begin
                if (result_ack) begin
                    result_valid_d = 1'b0;
                    tile_cnt_d     = '0;
                    acc_d          = '0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cur_q          <= '0;
            acc_q          <= '0;
            pend_q         <= '0;
            pend_full_q    <= 1'b0;
            overrun_q      <= 1'b0;
            tile_cnt_q     <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            a_stb_q        <= '0;
            b_stb_q        <= '0;
            z_ack_q        <= '0;
            lane_done_q    <= '0;
        end else begin
            state_q        <= state_d;
            cur_q          <= cur_d;
            acc_q          <= acc_d;
            pend_q         <= pend_d;
            pend_full_q    <= pend_full_d;
            overrun_q      <= overrun_d;
            tile_cnt_q     <= tile_cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            a_stb_q        <= a_stb_d;
            b_stb_q        <= b_stb_d;
            z_ack_q        <= z_ack_d;
            lane_done_q    <= lane_done_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = (state_q != IDLE);
    assign overrun      = overrun_q;
    assign tile_cnt     = tile_cnt_q;

endmodule

// File: tb/tb_tile_accumulator.sv
// Scoreboard bench for tile_accumulator: a real-valued model predicts each lane-wise sum,
// checked against a 4-tile instance and a single-tile instance.

module tb_tile_accumulator;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] c_in, c_in1;
    logic         c_done, c_done1, result_ack, result_ack1;
    logic [255:0] result, result1;
    logic         result_valid, result_valid1, busy, busy1, overrun, overrun1;
    logic [7:0]   tile_cnt, tile_cnt1;

    int           checks   = 0;
    int           failures = 0;
    logic [255:0] expQ[$];
    logic [255:0] expQ1[$];
    real          modelSum[4];
    int           modelCnt;
    logic         expOverrun;
    logic         strobeSeen1 = 1'b0;

    always #5 clk = ~clk;

    tile_accumulator #(.NUM_TILES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .c_in(c_in), .c_done(c_done),
        .result(result), .result_valid(result_valid), .result_ack(result_ack),
        .busy(busy), .overrun(overrun), .tile_cnt(tile_cnt)
    );

    tile_accumulator #(.NUM_TILES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .c_in(c_in1), .c_done(c_done1),
        .result(result1), .result_valid(result_valid1), .result_ack(result_ack1),
        .busy(busy1), .overrun(overrun1), .tile_cnt(tile_cnt1)
    );

    // The single-tile instance must never hand work to its adders.
    always @(posedge clk) begin
        if (dut1.a_stb_q != 4'h0 || dut1.b_stb_q != 4'h0) strobeSeen1 <= 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [255:0] packLanes(input real l0, input real l1, input real l2, input real l3);
        return {$realtobits(l3), $realtobits(l2), $realtobits(l1), $realtobits(l0)};
    endfunction

    task automatic clearModel();
        for (int i = 0; i < 4; i++) modelSum[i] = 0.0;
        modelCnt = 0;
    endtask

    task automatic scrambleInput();
        for (int i = 0; i < 8; i++) c_in[i*32 +: 32] = $urandom();
    endtask

    // Called at a negedge: drives one c_done pulse and records what the model expects.
    task automatic applyStimulus(input real l0, input real l1, input real l2, input real l3, input bit accepted);
        c_in   = packLanes(l0, l1, l2, l3);
        c_done = 1'b1;
        if (accepted) begin
            modelSum[0] += l0;
            modelSum[1] += l1;
            modelSum[2] += l2;
            modelSum[3] += l3;
            modelCnt++;
            if (modelCnt == 4) begin
                expQ.push_back(packLanes(modelSum[0], modelSum[1], modelSum[2], modelSum[3]));
                clearModel();
            end
        end else begin
            expOverrun = 1'b1;
        end
        @(negedge clk);
        c_done = 1'b0;
        scrambleInput();
    endtask

    task automatic spacedTiles(input real l0, input real l1, input real l2, input real l3, input int count);
        for (int t = 0; t < count; t++) begin
            applyStimulus(l0, l1, l2, l3, 1'b1);
            repeat (39) @(negedge clk);
        end
    endtask

    task automatic waitValid(input string tag);
        logic [255:0] expVal;
        int n = 0;
        while (!result_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!result_valid) begin
            checkOutput({tag, " valid timeout"}, 256'(result_valid), 256'(1));
            return;
        end
        if (expQ.size() == 0) begin
            checkOutput({tag, " scoreboard empty"}, 256'(expQ.size()), 256'(1));
            return;
        end
        expVal = expQ.pop_front();
        checkOutput({tag, " result"}, result, expVal);
        checkOutput({tag, " tile_cnt"}, 256'(tile_cnt), 256'(4));
        checkOutput({tag, " overrun"}, 256'(overrun), 256'(expOverrun));
    endtask

    task automatic ackResult(input string tag);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        checkOutput({tag, " valid after ack"}, 256'(result_valid), 256'(0));
        checkOutput({tag, " tile_cnt after ack"}, 256'(tile_cnt), 256'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [255:0] held, vec1;
        logic         stable;
        int           lat;

        rst = 1'b1;
        c_in = '0; c_in1 = '0;
        c_done = 1'b0; c_done1 = 1'b0;
        result_ack = 1'b0; result_ack1 = 1'b0;
        expOverrun = 1'b0;
        clearModel();
        repeat (3) @(negedge clk);

        checkOutput("reset result", result, 256'(0));
        checkOutput("reset valid", 256'(result_valid), 256'(0));
        checkOutput("reset busy", 256'(busy), 256'(0));
        checkOutput("reset overrun", 256'(overrun), 256'(0));
        checkOutput("reset tile_cnt", 256'(tile_cnt), 256'(0));
        checkOutput("reset valid1", 256'(result_valid1), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        spacedTiles(1.0, 1.0, 1.0, 1.0, 4);
        waitValid("basic");
        ackResult("basic");

        spacedTiles(1.0, 2.0, -1.0, 0.5, 4);
        waitValid("lanes");
        ackResult("lanes");

        applyStimulus(1.0, -2.0, 0.5, 3.0, 1'b1);
        applyStimulus(2.0, 4.0, -0.25, 1.0, 1'b1);
        checkOutput("b2b overrun pending", 256'(overrun), 256'(0));
        applyStimulus(100.0, 100.0, 100.0, 100.0, 1'b0);
        checkOutput("b2b overrun dropped", 256'(overrun), 256'(1));
        repeat (39) @(negedge clk);
        spacedTiles(4.0, 8.0, 0.125, -6.0, 1);
        spacedTiles(8.0, 1.0, 1.0, 1.0, 1);
        waitValid("b2b");
        ackResult("b2b");

        spacedTiles(1.5, -0.5, 0.25, -3.0, 4);
        waitValid("backpressure");
        held = result;
        applyStimulus(5.0, -2.0, 0.75, 10.0, 1'b1);
        stable = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (result !== held || result_valid !== 1'b1) stable = 1'b0;
        end
        checkOutput("bp held stable", 256'(stable), 256'(1));
        checkOutput("bp busy", 256'(busy), 256'(1));
        checkOutput("bp tile_cnt", 256'(tile_cnt), 256'(4));
        ackResult("backpressure");
        repeat (39) @(negedge clk);
        spacedTiles(1.5, -0.5, 0.25, -3.0, 3);
        waitValid("bp next");
        ackResult("bp next");

        spacedTiles(1.0, 1.0, 1.0, 1.0, 1);
        applyStimulus(3.0, 3.0, 3.0, 3.0, 1'b1);
        @(negedge clk);
        checkOutput("pre-reset strobes", 256'(dut.a_stb_q), 256'(4'hF));
        rst = 1'b1;
        #1;
        checkOutput("mid reset valid", 256'(result_valid), 256'(0));
        checkOutput("mid reset busy", 256'(busy), 256'(0));
        checkOutput("mid reset tile_cnt", 256'(tile_cnt), 256'(0));
        checkOutput("mid reset overrun", 256'(overrun), 256'(0));
        checkOutput("mid reset result", result, 256'(0));
        clearModel();
        expOverrun = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        spacedTiles(2.0, 2.0, 2.0, 2.0, 4);
        waitValid("after reset");
        ackResult("after reset");

        vec1 = packLanes(3.0, 3.0, 3.0, 3.0);
        c_in1 = vec1;
        c_done1 = 1'b1;
        expQ1.push_back(vec1);
        @(negedge clk);
        c_done1 = 1'b0;
        c_in1 = {8{32'hDEADBEEF}};
        lat = 1;
        while (!result_valid1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("nt1 latency", 256'(lat <= 3), 256'(1));
        checkOutput("nt1 result", result1, expQ1.pop_front());
        checkOutput("nt1 tile_cnt", 256'(tile_cnt1), 256'(1));
        checkOutput("nt1 no strobes", 256'(strobeSeen1), 256'(0));
        result_ack1 = 1'b1;
        @(negedge clk);
        result_ack1 = 1'b0;
        checkOutput("nt1 valid after ack", 256'(result_valid1), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
